// File: rtl/gpio_port_v2.sv
// gpio_port_v2: Avalon-MM parallel I/O port with per-bit direction, input synchroniser,
// rising/falling edge capture (write-1-to-clear), atomic set/clear and a level interrupt.
// readdata has 1-cycle latency; pin writes land 2 cycles after the bus write; no wait states.
// Optional macro GPIO_DEBOUNCE_EN adds a per-bit stability filter with DEB_LIMIT read at address 6.
module gpio_port_v2 #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  inout  wire [DW-1:0] gpio,
  output logic        irq,
  output logic [31:0] readdata
);

  localparam logic [2:0] A_DATA = 3'd0, A_DIR  = 3'd1, A_MASK = 3'd2, A_CAP = 3'd3,
                         A_RISE = 3'd4, A_FALL = 3'd5, A_SET  = 3'd6, A_CLR = 3'd7;

  logic [31:0]   be_mask;
  logic [DW-1:0] wbits, wmask;
  logic          wr_en, rd_en;

  logic [DW-1:0] data_q, data_d, out_q, out_d, dir_q, dir_d, mask_q, mask_d;
  logic [DW-1:0] cap_q, cap_d, rise_q, rise_d, fall_q, fall_d, prev_q, prev_d;
  logic [DW-1:0] sync_q [SYNC_STAGES];
  logic [DW-1:0] sync_d [SYNC_STAGES];
  logic [DW-1:0] in_val, clr_mask, new_cap;
  logic          irq_q, irq_d;
  logic [31:0]   readdata_q, readdata_d;

  assign be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign wmask   = be_mask[DW-1:0];
  assign wbits   = writedata[DW-1:0] & wmask;
  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;

  // Each pin drives only when its direction bit selects output
  for (genvar g = 0; g < DW; g++) begin : g_pin
    assign gpio[g] = dir_q[g] ? out_q[g] : 1'bz;
  end

  // Synchroniser chain: stage 0 samples the pins, last stage is the usable input
  always_comb begin
    sync_d[0] = gpio;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Synchroniser flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [DW-1:0]        deb_q, deb_d;
  logic [DEB_CNT_W-1:0] cnt_q [DW];
  logic [DEB_CNT_W-1:0] cnt_d [DW];
  logic [DEB_CNT_W-1:0] deb_limit_q, deb_limit_d;

  // Stability filter: follow the raw input only after it has differed for DEB_LIMIT+1 cycles
  always_comb begin
    deb_d       = deb_q;
    deb_limit_d = deb_limit_q;
    for (int i = 0; i < DW; i++) begin
      cnt_d[i] = '0;
      if (sync_q[SYNC_STAGES-1][i] != deb_q[i]) begin
        if (cnt_q[i] == deb_limit_q) deb_d[i] = sync_q[SYNC_STAGES-1][i];
        else                         cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Address 6 keeps its DATA_SET action; bit 31 additionally loads the limit
    if (wr_en && address == A_SET && writedata[31]) deb_limit_d = writedata[DEB_CNT_W-1:0];
  end

  // Debounce state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q       <= '0;
      deb_limit_q <= '0;
      for (int i = 0; i < DW; i++) cnt_q[i] <= '0;
    end else begin
      deb_q       <= deb_d;
      deb_limit_q <= deb_limit_d;
      for (int i = 0; i < DW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_val = deb_q;
`else
  assign in_val = sync_q[SYNC_STAGES-1];
`endif

  // Register writes, edge capture, interrupt and read mux
  always_comb begin
    data_d     = data_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    rise_d     = rise_q;
    fall_d     = fall_q;
    clr_mask   = '0;
    out_d      = data_q;
    prev_d     = in_val;
    readdata_d = readdata_q;
    if (wr_en) begin
      case (address)
        A_DATA:  data_d   = (data_q & ~wmask) | wbits;
        A_DIR:   dir_d    = (dir_q  & ~wmask) | wbits;
        A_MASK:  mask_d   = (mask_q & ~wmask) | wbits;
        A_CAP:   clr_mask = wbits;
        A_RISE:  rise_d   = (rise_q & ~wmask) | wbits;
        A_FALL:  fall_d   = (fall_q & ~wmask) | wbits;
        A_SET:   data_d   = data_q | wbits;
        default: data_d   = data_q & ~wbits;
      endcase
    end
    // A new edge outranks a same-cycle clear
    new_cap = ((in_val & ~prev_q) & rise_q) | ((~in_val & prev_q) & fall_q);
    cap_d   = (cap_q & ~clr_mask) | new_cap;
    irq_d   = |(cap_q & mask_q);
    if (rd_en) begin
      case (address)
        A_DATA:  readdata_d = 32'(in_val);
        A_DIR:   readdata_d = 32'(dir_q);
        A_MASK:  readdata_d = 32'(mask_q);
        A_CAP:   readdata_d = 32'(cap_q);
        A_RISE:  readdata_d = 32'(rise_q);
        A_FALL:  readdata_d = 32'(fall_q);
`ifdef GPIO_DEBOUNCE_EN
        A_SET:   readdata_d = 32'(deb_limit_q);
`endif
        default: readdata_d = '0;
      endcase
    end
  end

  // Main state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      out_q      <= '0;
      dir_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      prev_q     <= prev_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign irq      = irq_q;
  assign readdata = readdata_q;

endmodule
